// File: rtl/decrypt_sequencer.sv
// CPA decryption phase sequencer: walks unpack, multiply, inverse NTT, gamma multiply,
// subtract and decode, handshaking with external units and steering RAM bank selects.
module decrypt_sequencer #(
  parameter int LOG_N   = 9,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16,
  parameter int CNT_W   = 24,
  localparam int N          = 1 << LOG_N,
  localparam int POLY_BYTES = 14 * N / 8,
  localparam int CMP_BYTES  = 3 * N / 8,
  localparam int IR_W       = $clog2(2 * POLY_BYTES + CMP_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic             start_pd,
  input  logic             done_pd,
  output logic             start_decomp,
  input  logic             done_decomp,
  output logic             start_pa,
  input  logic             done_pa,
  output logic [1:0]       op_code_pa,
  output logic             start_ntt,
  input  logic             done_ntt,
  output logic             ntt_inverse,
  output logic             start_dec,
  input  logic             done_dec,
  output logic [2:0]       phase,
  output logic             host_access,
  output logic [IR_W-1:0]  ir_base_a,
  output logic [IR_W-1:0]  ir_base_b,
  output logic [1:0]       pr_bank_a,
  output logic [1:0]       pr_bank_b
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK_1, S_UNPACK_2, S_MULT, S_INV_NTT,
    S_GAMMA_MULT, S_SUB, S_DECODE, S_ERROR
  } state_t;

  state_t            state, state_nxt, succ;
  logic              idle_like, accept, awaited, enter;
  logic              decomp_seen, pd_seen;
  logic [TO_W-1:0]   wd_cnt;

  assign idle_like   = (state == S_IDLE) || (state == S_ERROR);
  assign accept      = idle_like && start;
  assign enter       = (state_nxt != state);
  assign ntt_inverse = 1'b1;
  assign ir_base_b   = IR_W'(POLY_BYTES);

  always_comb begin
    awaited   = 1'b0;
    succ      = S_IDLE;
    state_nxt = state;
    case (state)
      S_UNPACK_1:   begin awaited = done_pd;  succ = S_UNPACK_2;   end
      // Both units may finish in either order; each completion is latched until the other arrives.
      S_UNPACK_2:   begin
        awaited = (done_pd || pd_seen) && (done_decomp || decomp_seen);
        succ    = S_MULT;
      end
      S_MULT:       begin awaited = done_pa;  succ = S_INV_NTT;    end
      S_INV_NTT:    begin awaited = done_ntt; succ = S_GAMMA_MULT; end
      S_GAMMA_MULT: begin awaited = done_pa;  succ = S_SUB;        end
      S_SUB:        begin awaited = done_pa;  succ = S_DECODE;     end
      S_DECODE:     begin awaited = done_dec; succ = S_IDLE;       end
      default:      begin awaited = 1'b0;     succ = S_IDLE;       end
    endcase
    if (idle_like) begin
      if (start) state_nxt = S_UNPACK_1;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else if (awaited) begin
      state_nxt = succ;
    end else if (wd_cnt == TO_W'(TIMEOUT - 1)) begin
      state_nxt = S_ERROR;
    end
  end

  always_comb begin
    busy       = 1'b1;
    phase      = state[2:0];
    op_code_pa = 2'd0;
    pr_bank_a  = 2'd0;
    pr_bank_b  = 2'd0;
    ir_base_a  = '0;
    case (state)
      S_UNPACK_1:   begin pr_bank_a = 2'd3; pr_bank_b = 2'd2; end
      S_UNPACK_2:   begin
        pr_bank_a = 2'd1;
        pr_bank_b = 2'd2;
        ir_base_a = IR_W'(POLY_BYTES + CMP_BYTES);
      end
      S_MULT:       begin pr_bank_a = 2'd3; pr_bank_b = 2'd1; op_code_pa = 2'd0; end
      S_INV_NTT:    begin pr_bank_a = 2'd3; pr_bank_b = 2'd3; end
      S_GAMMA_MULT: begin pr_bank_a = 2'd3; pr_bank_b = 2'd0; op_code_pa = 2'd3; end
      S_SUB:        begin pr_bank_a = 2'd3; pr_bank_b = 2'd2; op_code_pa = 2'd2; end
      S_DECODE:     begin pr_bank_a = 2'd3; pr_bank_b = 2'd0; end
      default:      begin busy = 1'b0; phase = 3'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wd_cnt       <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 3'd0;
      decomp_seen  <= 1'b0;
      pd_seen      <= 1'b0;
      start_pd     <= 1'b0;
      start_decomp <= 1'b0;
      start_pa     <= 1'b0;
      start_ntt    <= 1'b0;
      start_dec    <= 1'b0;
      host_access  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= enter ? '0 : (busy ? wd_cnt + 1'b1 : wd_cnt);
      done   <= (state == S_DECODE) && done_dec && !abort;

      if (accept)                                 cycle_count <= '0;
      else if (busy && (cycle_count != '1))       cycle_count <= cycle_count + 1'b1;

      if (accept) begin
        error    <= 1'b0;
        err_code <= 3'd0;
      end else if (busy && (state_nxt == S_ERROR)) begin
        error    <= 1'b1;
        err_code <= phase;
      end

      if (accept)                                                  decomp_seen <= 1'b0;
      else if (done_decomp && ((state == S_UNPACK_1) || (state == S_UNPACK_2))) decomp_seen <= 1'b1;
      if (accept)                                 pd_seen <= 1'b0;
      else if (done_pd && (state == S_UNPACK_2))  pd_seen <= 1'b1;

      // Start strobes fire only on the cycle a state is entered.
      start_pd     <= enter && ((state_nxt == S_UNPACK_1) || (state_nxt == S_UNPACK_2));
      start_decomp <= enter && (state_nxt == S_UNPACK_1);
      start_pa     <= enter && ((state_nxt == S_MULT) || (state_nxt == S_GAMMA_MULT) ||
                                (state_nxt == S_SUB));
      start_ntt    <= enter && (state_nxt == S_INV_NTT);
      start_dec    <= enter && (state_nxt == S_DECODE);
      host_access  <= (state_nxt == S_IDLE) || (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer: two instances (N=512 long watchdog, N=1024 short
// watchdog) with responder stubs; run results are checked against a scoreboard of expectations.
module tb_decrypt_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sel;
  logic start0, start1, abort0, abort1;
  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign abort0 = abort & ~sel;
  assign abort1 = abort & sel;

  // unit order: 0 pd, 1 decomp, 2 pa, 3 ntt, 4 dec
  logic [4:0]  st0, dn0, st1, dn1;
  logic        busy0, done0, error0, inv0, ha0, busy1, done1, error1, inv1, ha1;
  logic [2:0]  ec0, ph0, ec1, ph1;
  logic [23:0] cc0, cc1;
  logic [1:0]  op0, pa0, pb0, op1, pa1, pb1;
  logic [10:0] ira0, irb0;
  logic [11:0] ira1, irb1;

  decrypt_sequencer #(.LOG_N(9), .TIMEOUT(64), .TO_W(16), .CNT_W(24)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .error(error0), .err_code(ec0), .cycle_count(cc0),
    .start_pd(st0[0]), .done_pd(dn0[0]), .start_decomp(st0[1]), .done_decomp(dn0[1]),
    .start_pa(st0[2]), .done_pa(dn0[2]), .op_code_pa(op0), .start_ntt(st0[3]),
    .done_ntt(dn0[3]), .ntt_inverse(inv0), .start_dec(st0[4]), .done_dec(dn0[4]),
    .phase(ph0), .host_access(ha0), .ir_base_a(ira0), .ir_base_b(irb0),
    .pr_bank_a(pa0), .pr_bank_b(pb0));

  decrypt_sequencer #(.LOG_N(10), .TIMEOUT(16), .TO_W(16), .CNT_W(24)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .error(error1), .err_code(ec1), .cycle_count(cc1),
    .start_pd(st1[0]), .done_pd(dn1[0]), .start_decomp(st1[1]), .done_decomp(dn1[1]),
    .start_pa(st1[2]), .done_pa(dn1[2]), .op_code_pa(op1), .start_ntt(st1[3]),
    .done_ntt(dn1[3]), .ntt_inverse(inv1), .start_dec(st1[4]), .done_dec(dn1[4]),
    .phase(ph1), .host_access(ha1), .ir_base_a(ira1), .ir_base_b(irb1),
    .pr_bank_a(pa1), .pr_bank_b(pb1));

  // Responder stubs: done pulses dly[u] cycles after the start pulse; 0 = never respond.
  int dly[5];
  int cnt0[5], cnt1[5];
  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 5; u++) begin
      if (rst) begin
        cnt0[u] <= 0; cnt1[u] <= 0; dn0[u] <= 1'b0; dn1[u] <= 1'b0;
      end else begin
        dn0[u] <= 1'b0;
        dn1[u] <= 1'b0;
        if (st0[u]) begin
          if (dly[u] == 1) dn0[u] <= 1'b1; else if (dly[u] > 1) cnt0[u] <= dly[u] - 1;
        end else if (cnt0[u] > 0) begin
          if (cnt0[u] == 1) dn0[u] <= 1'b1;
          cnt0[u] <= cnt0[u] - 1;
        end
        if (st1[u]) begin
          if (dly[u] == 1) dn1[u] <= 1'b1; else if (dly[u] > 1) cnt1[u] <= dly[u] - 1;
        end else if (cnt1[u] > 0) begin
          if (cnt1[u] == 1) dn1[u] <= 1'b1;
          cnt1[u] <= cnt1[u] - 1;
        end
      end
    end
  end

  // Selected-instance view
  logic        busy_v, done_v, error_v, ha_v;
  logic [2:0]  ec_v, ph_v;
  logic [23:0] cc_v;
  logic [1:0]  op_v, pa_v, pb_v;
  logic [11:0] ira_v;
  logic [4:0]  st_v, dn_v;
  assign busy_v  = sel ? busy1 : busy0;
  assign done_v  = sel ? done1 : done0;
  assign error_v = sel ? error1 : error0;
  assign ha_v    = sel ? ha1 : ha0;
  assign ec_v    = sel ? ec1 : ec0;
  assign ph_v    = sel ? ph1 : ph0;
  assign cc_v    = sel ? cc1 : cc0;
  assign op_v    = sel ? op1 : op0;
  assign pa_v    = sel ? pa1 : pa0;
  assign pb_v    = sel ? pb1 : pb0;
  assign ira_v   = sel ? ira1 : {1'b0, ira0};
  assign st_v    = sel ? st1 : st0;
  assign dn_v    = sel ? dn1 : dn0;

  function automatic int pack(int p, int a, int b, int ir);
    return p * 1000000 + a * 100000 + b * 10000 + ir;
  endfunction

  // Monitor: cumulative event counters plus observed op codes and per-phase bank selects.
  int n_busy, n_done, n_sdec, n_ntt, n_u2;
  bit [2:0] prev_ph;
  int op_q[$], bank_q[$];
  always @(negedge clk) begin
    if (busy_v)         n_busy <= n_busy + 1;
    if (done_v)         n_done <= n_done + 1;
    if (st_v[4])        n_sdec <= n_sdec + 1;
    if (ph_v == 3'd4)   n_ntt  <= n_ntt + 1;
    if (ph_v == 3'd2)   n_u2   <= n_u2 + 1;
    if (st_v[2])        op_q.push_back(int'(op_v));
    if ((ph_v != prev_ph) && (ph_v != 3'd0))
      bank_q.push_back(pack(int'(ph_v), int'(pa_v), int'(pb_v), int'(ira_v)));
    prev_ph <= ph_v;
  end

  int n_chk, n_pass, n_fail;
  int exp_cc_q[$], exp_op_q[$], exp_bank_q[$];
  int s_done, s_sdec, s_ntt, s_u2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_begin(input int exp_cc, input int ir_u2);
    exp_cc_q.push_back(exp_cc);
    exp_op_q.push_back(0); exp_op_q.push_back(3); exp_op_q.push_back(2);
    exp_bank_q.push_back(pack(1, 3, 2, 0));
    exp_bank_q.push_back(pack(2, 1, 2, ir_u2));
    exp_bank_q.push_back(pack(3, 3, 1, 0));
    exp_bank_q.push_back(pack(4, 3, 3, 0));
    exp_bank_q.push_back(pack(5, 3, 0, 0));
    exp_bank_q.push_back(pack(6, 3, 2, 0));
    exp_bank_q.push_back(pack(7, 3, 0, 0));
    op_q.delete();
    bank_q.delete();
    s_done = n_done; s_sdec = n_sdec; s_ntt = n_ntt; s_u2 = n_u2;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while ((busy_v === 1'b1) && (k < maxc)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_completes"}, 32'(k < maxc), 1);
    #1;
  endtask

  task automatic end_checks(input string tag);
    int e, o;
    e = exp_cc_q.pop_front();
    chk({tag, "_cycle_count"}, 32'(cc_v), e);
    chk({tag, "_done_pulses"}, n_done - s_done, 1);
    chk({tag, "_error"}, 32'(error_v), 0);
    while (exp_op_q.size() > 0) begin
      e = exp_op_q.pop_front();
      if (op_q.size() > 0) o = op_q.pop_front(); else o = -1;
      chk({tag, "_op_code"}, o, e);
    end
    chk({tag, "_extra_ops"}, op_q.size(), 0);
    while (exp_bank_q.size() > 0) begin
      e = exp_bank_q.pop_front();
      if (bank_q.size() > 0) o = bank_q.pop_front(); else o = -1;
      chk({tag, "_bank_map"}, o, e);
    end
    chk({tag, "_extra_phases"}, bank_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    for (int u = 0; u < 5; u++) dly[u] = 4;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_error", 32'(error0), 0);
    chk("rst_err_code", 32'(ec0), 0);
    chk("rst_cycle_count", 32'(cc0), 0);
    chk("rst_phase", 32'(ph0), 0);
    chk("rst_starts", 32'(st0), 0);
    chk("rst_host_access", 32'(ha0), 0);
    chk("rst_banks", {pa0, pb0, ira0}, 0);
    chk("rst_ntt_inverse", 32'(inv0), 1);
    chk("rst_ir_base_b", 32'(irb0), 896);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_host_access", 32'(ha0), 1);

    // Nominal run, with a start pulse mid-run that must be ignored
    run_begin(35, 1088);
    start_pulse();
    chk("run_busy", 32'(busy0), 1);
    repeat (10) @(negedge clk);
    start_pulse();
    wait_idle("nominal", 200);
    end_checks("nominal");

    // Decompressor finishes long after the second polynomial decode
    dly[1] = 20;
    run_begin(46, 1088);
    start_pulse();
    wait_idle("decomp", 200);
    chk("decomp_unpack2_cycles", n_u2 - s_u2, 16);
    end_checks("decomp");
    dly[1] = 4;

    // Abort in SUB on the same cycle as done_pa
    s_done = n_done; s_sdec = n_sdec;
    start_pulse();
    k = 0;
    while (!((ph_v == 3'd6) && st_v[2]) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_sub", 32'(k < 100), 1);
    repeat (4) @(negedge clk);
    chk("abort_done_pa_coincides", 32'(dn_v[2]), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy_v), 0);
    chk("abort_phase", 32'(ph_v), 0);
    chk("abort_cycle_count", 32'(cc_v), 30);
    repeat (8) @(negedge clk);
    chk("abort_count_frozen", 32'(cc_v), 30);
    chk("abort_no_done", n_done - s_done, 0);
    chk("abort_no_start_dec", n_sdec - s_sdec, 0);
    chk("abort_error", 32'(error_v), 0);
    chk("abort_host_access", 32'(ha_v), 1);

    // Abort is ignored while idle; then asynchronous reset during MULT
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_start_busy", 32'(busy_v), 1);
    chk("idle_abort_start_phase", 32'(ph_v), 1);
    k = 0;
    while ((ph_v != 3'd3) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_mult", 32'(k < 100), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy_v), 0);
    chk("async_rst_phase", 32'(ph_v), 0);
    chk("async_rst_cycle_count", 32'(cc_v), 0);
    chk("async_rst_op_code", 32'(op_v), 0);
    chk("async_rst_banks", {pa_v, pb_v}, 0);
    chk("async_rst_host_access", 32'(ha_v), 0);
    run_begin(35, 1088);
    @(negedge clk);
    rst = 1'b0;
    start_pulse();
    chk("post_rst_start_phase", 32'(ph_v), 1);
    wait_idle("post_rst", 200);
    end_checks("post_rst");

    // N=1024, watchdog 16: ntt never responds
    sel = 1'b1;
    dly[3] = 0;
    s_done = n_done; s_ntt = n_ntt;
    start_pulse();
    wait_idle("timeout", 300);
    chk("timeout_error", 32'(error_v), 1);
    chk("timeout_err_code", 32'(ec_v), 4);
    chk("timeout_busy", 32'(busy_v), 0);
    chk("timeout_phase", 32'(ph_v), 0);
    chk("timeout_ntt_cycles", n_ntt - s_ntt, 16);
    chk("timeout_cycle_count", 32'(cc_v), 31);
    chk("timeout_no_done", n_done - s_done, 0);
    chk("timeout_host_access", 32'(ha_v), 1);

    // Restart from ERROR clears the error; N=1024 bank map
    dly[3] = 4;
    run_begin(35, 2176);
    start_pulse();
    chk("restart_error_cleared", 32'(error_v), 0);
    chk("restart_err_code_cleared", 32'(ec_v), 0);
    chk("n1024_ir_base_b", 32'(irb1), 1792);
    wait_idle("n1024", 200);
    end_checks("n1024");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
